iterative_alu_unit: RTL and testbench

- Execute-stage datapath unit. Consumes the 4-bit Operation code from the ALU controller, together with operands from the ID/EX register.
- Single-cycle ops (logic, add/sub, shifts, SLT) finish in 1 cycle.
- MUL and DIVU/REMU run iteratively over 32 cycles, one bit per cycle.
- Valid/ready handshakes on both sides. The hazard unit uses busy to stall IF/ID/EX while a multi-cycle op is in flight.

---
 rtl/alu_pkg.sv | 29 ++
 rtl/iterative_alu_unit_if.sv | 26 ++
 rtl/iter_muldiv.sv | 70 +++++++
 rtl/iterative_alu_unit.sv | 118 +++++++++++
 tb/tb_iterative_alu_unit.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared types and constants for the iterative execute-stage ALU.
// Operation codes, FSM states and default widths.
package alu_pkg;

    localparam int DATA_W = 32;
    localparam int CNT_W  = 6;

    typedef enum logic [3:0] {
        OP_AND  = 4'b0000,
        OP_OR   = 4'b0001,
        OP_ADD  = 4'b0010,
        OP_XOR  = 4'b0011,
        OP_SLL  = 4'b0100,
        OP_SRL  = 4'b0101,
        OP_SUB  = 4'b0110,
        OP_SLT  = 4'b0111,
        OP_SRA  = 4'b1000,
        OP_MUL  = 4'b1001,
        OP_DIVU = 4'b1010,
        OP_REMU = 4'b1011
    } alu_op_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } state_t;

endpackage

// File: rtl/iterative_alu_unit_if.sv
// Operand/result handshake bundle between ID/EX, the ALU and EX/MEM.
// master = pipeline side, slave = ALU.
interface iterative_alu_unit_if #(
    parameter int DATA_W = alu_pkg::DATA_W
);
    logic              in_valid;
    logic              in_ready;
    logic [3:0]        Operation;
    logic [DATA_W-1:0] SrcA;
    logic [DATA_W-1:0] SrcB;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] ALUResult;
    logic              Zero;
    logic              busy;

    modport master (
        output in_valid, Operation, SrcA, SrcB, out_ready,
        input  in_ready, out_valid, ALUResult, Zero, busy
    );

    modport slave (
        input  in_valid, Operation, SrcA, SrcB, out_ready,
        output in_ready, out_valid, ALUResult, Zero, busy
    );
endinterface

// File: rtl/iter_muldiv.sv
// Bit-serial shift-add multiplier and restoring divider.
// Shares one register set: x = multiplicand/divisor, y = multiplier/quotient.
module iter_muldiv import alu_pkg::*; #(
    parameter int DATA_W = alu_pkg::DATA_W,
    parameter int CNT_W  = alu_pkg::CNT_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              i_start,
    input  logic              i_step,
    input  logic              i_div,
    input  logic              i_rem,
    input  logic [DATA_W-1:0] i_a,
    input  logic [DATA_W-1:0] i_b,
    output logic              o_done,
    output logic [DATA_W-1:0] o_result
);
    logic [DATA_W-1:0] r_x;
    logic [DATA_W-1:0] r_y;
    logic [DATA_W-1:0] r_acc;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_div;
    logic              r_rem;

    logic [DATA_W-1:0] w_madd;
    logic [DATA_W:0]   w_shift;
    logic [DATA_W:0]   w_sub;
    logic              w_ge;
    logic [DATA_W-1:0] w_acc_nxt;
    logic [DATA_W-1:0] w_y_nxt;
    logic [DATA_W-1:0] w_x_nxt;

    assign w_madd  = r_acc + (r_y[0] ? r_x : '0);
    // Bring the next dividend bit into the partial remainder, then trial-subtract.
    assign w_shift = {r_acc, r_y[DATA_W-1]};
    assign w_sub   = w_shift - {1'b0, r_x};
    assign w_ge    = ~w_sub[DATA_W];

    assign w_acc_nxt = r_div ? (w_ge ? w_sub[DATA_W-1:0] : w_shift[DATA_W-1:0])
                             : w_madd;
    assign w_y_nxt   = r_div ? {r_y[DATA_W-2:0], w_ge} : (r_y >> 1);
    assign w_x_nxt   = r_div ? r_x : (r_x << 1);

    assign o_done   = i_step && (r_cnt == CNT_W'(DATA_W - 1));
    assign o_result = (r_div && !r_rem) ? w_y_nxt : w_acc_nxt;

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            r_x   <= '0;
            r_y   <= '0;
            r_acc <= '0;
            r_cnt <= '0;
            r_div <= 1'b0;
            r_rem <= 1'b0;
        end else if (i_start) begin
            r_x   <= i_div ? i_b : i_a;
            r_y   <= i_div ? i_a : i_b;
            r_acc <= '0;
            r_cnt <= '0;
            r_div <= i_div;
            r_rem <= i_rem;
        end else if (i_step) begin
            r_x   <= w_x_nxt;
            r_y   <= w_y_nxt;
            r_acc <= w_acc_nxt;
            r_cnt <= o_done ? '0 : r_cnt + 1'b1;
        end
    end
endmodule

// File: rtl/iterative_alu_unit.sv
// Execute-stage ALU: single-cycle ops plus 32-cycle MUL/DIVU/REMU.
// Owns the handshake FSM, the fast-path ops and the result register.
module iterative_alu_unit import alu_pkg::*; #(
    parameter int DATA_W = alu_pkg::DATA_W,
    parameter int CNT_W  = alu_pkg::CNT_W
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 flush,
    iterative_alu_unit_if.slave  bus
);
    state_t            r_state;
    logic              r_valid;
    logic [DATA_W-1:0] r_result;
    logic              r_zero;
    logic              r_busy;

    logic [3:0]        w_op;
    logic [4:0]        w_shamt;
    logic              w_div0;
    logic              w_is_div;
    logic              w_iter;
    logic              w_accept;
    logic [DATA_W-1:0] w_single;
    logic              w_md_done;
    logic [DATA_W-1:0] w_md_result;

    assign w_op     = bus.Operation;
    assign w_shamt  = bus.SrcB[4:0];
    assign w_div0   = (bus.SrcB == '0);
    assign w_is_div = (w_op == OP_DIVU) || (w_op == OP_REMU);
    assign w_iter   = (w_op == OP_MUL) || (w_is_div && !w_div0);

    assign bus.in_ready  = (r_state == S_IDLE) ||
                           (r_state == S_DONE && bus.out_ready);
    assign w_accept      = bus.in_valid && bus.in_ready;
    assign bus.out_valid = r_valid;
    assign bus.ALUResult = r_result;
    assign bus.Zero      = r_zero;
    assign bus.busy      = r_busy;

    always_comb begin
        w_single = '0;
        unique case (w_op)
            OP_AND:  w_single = bus.SrcA & bus.SrcB;
            OP_OR:   w_single = bus.SrcA | bus.SrcB;
            OP_ADD:  w_single = bus.SrcA + bus.SrcB;
            OP_XOR:  w_single = bus.SrcA ^ bus.SrcB;
            OP_SLL:  w_single = bus.SrcA << w_shamt;
            OP_SRL:  w_single = bus.SrcA >> w_shamt;
            OP_SUB:  w_single = bus.SrcA - bus.SrcB;
            OP_SLT:  w_single = DATA_W'($signed(bus.SrcA) < $signed(bus.SrcB));
            OP_SRA:  w_single = DATA_W'($signed(bus.SrcA) >>> w_shamt);
            OP_DIVU: w_single = '1;
            OP_REMU: w_single = bus.SrcA;
            default: w_single = '0;
        endcase
    end

    iter_muldiv #(
        .DATA_W (DATA_W),
        .CNT_W  (CNT_W)
    ) u_muldiv (
        .clk      (clk),
        .reset    (reset),
        .flush    (flush),
        .i_start  (w_accept && w_iter),
        .i_step   (r_busy),
        .i_div    (w_is_div),
        .i_rem    (w_op == OP_REMU),
        .i_a      (bus.SrcA),
        .i_b      (bus.SrcB),
        .o_done   (w_md_done),
        .o_result (w_md_result)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_valid  <= 1'b0;
            r_result <= '0;
            r_zero   <= 1'b1;
            r_busy   <= 1'b0;
        end else if (flush) begin
            r_state <= S_IDLE;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE, S_DONE: begin
                    if (w_accept && w_iter) begin
                        r_state <= S_BUSY;
                        r_busy  <= 1'b1;
                        r_valid <= 1'b0;
                    end else if (w_accept) begin
                        r_state  <= S_DONE;
                        r_valid  <= 1'b1;
                        r_result <= w_single;
                        r_zero   <= (w_single == '0);
                    end else if (r_state == S_DONE && bus.out_ready) begin
                        r_state <= S_IDLE;
                        r_valid <= 1'b0;
                    end
                end
                S_BUSY: begin
                    if (w_md_done) begin
                        r_state  <= S_DONE;
                        r_busy   <= 1'b0;
                        r_valid  <= 1'b1;
                        r_result <= w_md_result;
                        r_zero   <= (w_md_result == '0);
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_iterative_alu_unit.sv
// Directed and random checks of iterative_alu_unit against an arithmetic model.
module tb_iterative_alu_unit;
    logic clk = 1'b0;
    logic reset;
    logic flush;
    int   compared = 0;
    int   mismatched = 0;

    iterative_alu_unit_if bus ();

    iterative_alu_unit dut (
        .clk   (clk),
        .reset (reset),
        .flush (flush),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
            $error("%s observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        logic signed [31:0] sa;
        logic [63:0] p;
        sa = a;
        p = 64'(a) * 64'(b);
        case (op)
            4'd0:  return a & b;
            4'd1:  return a | b;
            4'd2:  return a + b;
            4'd3:  return a ^ b;
            4'd4:  return a << b[4:0];
            4'd5:  return a >> b[4:0];
            4'd6:  return a - b;
            4'd7:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd8:  return sa >>> b[4:0];
            4'd9:  return p[31:0];
            4'd10: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            4'd11: return (b == 0) ? a : a % b;
            default: return 32'd0;
        endcase
    endfunction

    function automatic int model_lat(input logic [3:0] op, input logic [31:0] b);
        if (op == 4'd9) return 33;
        if ((op == 4'd10 || op == 4'd11) && b != 0) return 33;
        return 1;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Runs one op from IDLE with out_ready=1 and checks latency, result and Zero.
    task automatic go(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input string tag);
        logic [31:0] exp;
        int lat;
        int exp_lat;
        exp = model(op, a, b);
        exp_lat = model_lat(op, b);
        bus.out_ready = 1'b1;
        bus.in_valid = 1'b1;
        bus.Operation = op;
        bus.SrcA = a;
        bus.SrcB = b;
        check({tag, " in_ready"}, 32'(bus.in_ready), 32'd1);
        step();
        bus.in_valid = 1'b0;
        bus.Operation = 4'($urandom);
        bus.SrcA = $urandom;
        bus.SrcB = $urandom;
        lat = 1;
        while (!bus.out_valid && lat < 60) begin
            check({tag, " busy"}, 32'(bus.busy), 32'd1);
            check({tag, " in_ready_busy"}, 32'(bus.in_ready), 32'd0);
            step();
            lat++;
        end
        check({tag, " latency"}, 32'(lat), 32'(exp_lat));
        check({tag, " result"}, bus.ALUResult, exp);
        check({tag, " zero"}, 32'(bus.Zero), 32'(exp == 0));
        check({tag, " busy_done"}, 32'(bus.busy), 32'd0);
        step();
        check({tag, " valid_drop"}, 32'(bus.out_valid), 32'd0);
    endtask

    initial begin
        logic [31:0] last;
        logic [3:0]  rop;
        logic [31:0] ra;
        logic [31:0] rb;
        int lat;
        int seen;

        reset = 1'b1;
        flush = 1'b0;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        bus.Operation = 4'd0;
        bus.SrcA = '0;
        bus.SrcB = '0;
        step();
        step();
        reset = 1'b0;
        check("rst out_valid", 32'(bus.out_valid), 32'd0);
        check("rst result", bus.ALUResult, 32'd0);
        check("rst zero", 32'(bus.Zero), 32'd1);
        check("rst busy", 32'(bus.busy), 32'd0);
        check("rst in_ready", 32'(bus.in_ready), 32'd1);

        // Back-to-back ADD then SUB
        bus.in_valid = 1'b1;
        bus.Operation = 4'd2;
        bus.SrcA = 32'd5;
        bus.SrcB = 32'd7;
        step();
        check("b2b add valid", 32'(bus.out_valid), 32'd1);
        check("b2b add result", bus.ALUResult, 32'd12);
        check("b2b add zero", 32'(bus.Zero), 32'd0);
        check("b2b in_ready", 32'(bus.in_ready), 32'd1);
        bus.Operation = 4'd6;
        bus.SrcA = 32'd7;
        bus.SrcB = 32'd7;
        step();
        bus.in_valid = 1'b0;
        check("b2b sub valid", 32'(bus.out_valid), 32'd1);
        check("b2b sub result", bus.ALUResult, 32'd0);
        check("b2b sub zero", 32'(bus.Zero), 32'd1);
        step();
        check("b2b idle", 32'(bus.out_valid), 32'd0);

        go(4'd9, 32'h0001_0003, 32'h0000_0005, "mul");
        go(4'd10, 32'd100, 32'd7, "divu");
        go(4'd11, 32'd100, 32'd7, "remu");
        go(4'd10, 32'd9, 32'd0, "divu0");
        go(4'd11, 32'd9, 32'd0, "remu0");
        go(4'd7, 32'hFFFF_FFFF, 32'd1, "slt");
        go(4'd8, 32'h8000_0000, 32'd4, "sra");
        go(4'd4, 32'h0000_0003, 32'h21, "sll");
        go(4'd5, 32'h8000_0000, 32'd31, "srl");
        go(4'd12, 32'h1234_5678, 32'd3, "undef");
        go(4'd10, 32'hFFFF_FFFF, 32'd1, "divu_max");

        // Result held while downstream stalls
        bus.out_ready = 1'b0;
        bus.in_valid = 1'b1;
        bus.Operation = 4'd9;
        bus.SrcA = 32'h0001_0003;
        bus.SrcB = 32'h0000_0005;
        step();
        bus.in_valid = 1'b0;
        lat = 1;
        while (!bus.out_valid && lat < 60) begin
            step();
            lat++;
        end
        check("hold latency", 32'(lat), 32'd33);
        for (int i = 0; i < 5; i++) begin
            bus.in_valid = 1'b1;
            bus.Operation = 4'd2;
            bus.SrcA = 32'd1;
            bus.SrcB = 32'd1;
            check("hold in_ready", 32'(bus.in_ready), 32'd0);
            step();
            check("hold valid", 32'(bus.out_valid), 32'd1);
            check("hold result", bus.ALUResult, 32'h0005_000F);
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        step();
        check("hold release", 32'(bus.out_valid), 32'd0);
        last = 32'h0005_000F;

        // Flush in the 10th BUSY cycle of a DIVU; the same-cycle request is dropped
        bus.in_valid = 1'b1;
        bus.Operation = 4'd10;
        bus.SrcA = 32'd100;
        bus.SrcB = 32'd7;
        step();
        bus.in_valid = 1'b0;
        for (int i = 1; i < 10; i++) step();
        check("flush pre busy", 32'(bus.busy), 32'd1);
        flush = 1'b1;
        bus.in_valid = 1'b1;
        bus.Operation = 4'd2;
        bus.SrcA = 32'd1;
        bus.SrcB = 32'd2;
        step();
        flush = 1'b0;
        bus.in_valid = 1'b0;
        check("flush busy", 32'(bus.busy), 32'd0);
        check("flush valid", 32'(bus.out_valid), 32'd0);
        check("flush in_ready", 32'(bus.in_ready), 32'd1);
        check("flush result kept", bus.ALUResult, last);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (bus.out_valid) seen++;
        end
        check("flush no late result", 32'(seen), 32'd0);

        // Reset in the middle of a MUL
        bus.in_valid = 1'b1;
        bus.Operation = 4'd9;
        bus.SrcA = 32'd3;
        bus.SrcB = 32'd4;
        step();
        bus.in_valid = 1'b0;
        for (int i = 0; i < 5; i++) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("mrst out_valid", 32'(bus.out_valid), 32'd0);
        check("mrst result", bus.ALUResult, 32'd0);
        check("mrst zero", 32'(bus.Zero), 32'd1);
        check("mrst busy", 32'(bus.busy), 32'd0);
        check("mrst in_ready", 32'(bus.in_ready), 32'd1);
        go(4'd9, 32'hDEAD_BEEF, 32'h0000_1001, "mul_after_rst");

        for (int i = 0; i < 40; i++) begin
            rop = 4'($urandom_range(0, 15));
            ra = $urandom;
            case ($urandom_range(0, 3))
                0: rb = 32'd0;
                1: rb = 32'($urandom_range(1, 300));
                default: rb = $urandom;
            endcase
            go(rop, ra, rb, $sformatf("rnd%0d_op%0d", i, rop));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
